sram_controller: RTL and testbench



---
 rtl/sram_pkg.sv | 36 +++
 rtl/sram_phase_counter.sv | 37 +++
 rtl/sram_controller.sv | 129 ++++++++++++
 tb/tb_sram_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types, default parameters and address helper for the external
// 16-bit SRAM controller.
package sram_pkg;

   localparam int unsigned DEF_BASE_ADDR    = 1024;
   localparam int unsigned DEF_PHASE_CYCLES = 3;
   localparam int unsigned DEF_SRAM_AW      = 18;
   localparam int unsigned DATA_W           = 32;
   localparam int unsigned HALF_W           = 16;
   localparam int unsigned CNT_W            = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_e;

   // Request fields latched when an access is accepted in IDLE.
   typedef struct packed {
      logic              is_wr;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   // Half-word address: ((address - base) >> 2) word index, half selects
   // the low (0) or high (1) half-word. Caller truncates to the bus width.
   function automatic logic [DATA_W-1:0] map_addr(
      input logic [DATA_W-1:0] address,
      input logic              half,
      input logic [DATA_W-1:0] base = DATA_W'(DEF_BASE_ADDR)
   );
      return (((address - base) >> 2) << 1) | {{(DATA_W-1){1'b0}}, half};
   endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Per-phase cycle counter: loads PHASE_CYCLES-1 on phase entry and counts
// down to zero; last_o flags the final cycle of the phase.
// Ports: clk, rst (sync, active high), load_i (phase entry), last_o.
module sram_phase_counter
   import sram_pkg::*;
#(
   parameter int unsigned PHASE_CYCLES = DEF_PHASE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   output logic last_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Load on phase entry, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_W'(PHASE_CYCLES - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == '0);

endmodule

// File: rtl/sram_controller.sv
// Bridges 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as
// two sequential half-word accesses; ready low freezes the pipeline.
// Ports: clk, rst (sync, active high); rd_en, wr_en, address, write_data
// from the MEM stage; read_data to MEM/WB; ready (combinational);
// SRAM_DQ (bidirectional), SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N,
// SRAM_UB_N, SRAM_LB_N to the SRAM.
module sram_controller
   import sram_pkg::*;
#(
   parameter int unsigned BASE_ADDR    = DEF_BASE_ADDR,
   parameter int unsigned PHASE_CYCLES = DEF_PHASE_CYCLES,
   parameter int unsigned SRAM_AW      = DEF_SRAM_AW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rd_en,
   input  logic                wr_en,
   input  logic [DATA_W-1:0]   address,
   input  logic [DATA_W-1:0]   write_data,
   output logic [DATA_W-1:0]   read_data,
   output logic                ready,
   inout  wire  [HALF_W-1:0]   SRAM_DQ,
   output logic [SRAM_AW-1:0]  SRAM_ADDR,
   output logic                SRAM_WE_N,
   output logic                SRAM_OE_N,
   output logic                SRAM_CE_N,
   output logic                SRAM_UB_N,
   output logic                SRAM_LB_N
);

   localparam bit SINGLE_CYCLE = (PHASE_CYCLES == 1);

   state_e              state_q, state_d;
   req_t                req_q, req_d;
   logic [DATA_W-1:0]   read_data_q, read_data_d;
   logic                req;
   logic                phase_last;
   logic                phase_load;
   logic                we_n_c;
   logic                dq_oe_c;
   logic [HALF_W-1:0]   dq_out_c;
   logic [SRAM_AW-1:0]  addr_c;

   assign req        = rd_en | wr_en;
   assign phase_load = ((state_q == IDLE) && req) || ((state_q == LOW) && phase_last);

   sram_phase_counter #(
      .PHASE_CYCLES (PHASE_CYCLES)
   ) u_phase_cnt (
      .clk    (clk),
      .rst    (rst),
      .load_i (phase_load),
      .last_o (phase_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req)        state_d = LOW;
         LOW:     if (phase_last) state_d = HIGH;
         HIGH:    if (phase_last) state_d = DONE;
         DONE:                    state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   // Request latch and read capture; write wins when both enables are high.
   always_comb begin
      req_d       = req_q;
      read_data_d = read_data_q;
      if ((state_q == IDLE) && req) begin
         req_d.is_wr = wr_en;
         req_d.addr  = address;
         req_d.wdata = write_data;
      end
      if (!req_q.is_wr && phase_last) begin
         if (state_q == LOW)  read_data_d[HALF_W-1:0]      = SRAM_DQ;
         if (state_q == HIGH) read_data_d[DATA_W-1:HALF_W] = SRAM_DQ;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q       <= '0;
         read_data_q <= '0;
      end else begin
         req_q       <= req_d;
         read_data_q <= read_data_d;
      end
   end

   // Output decode; WE_N rises on the last phase cycle while DQ is still held.
   always_comb begin
      we_n_c   = 1'b1;
      dq_oe_c  = 1'b0;
      dq_out_c = '0;
      addr_c   = '0;
      ready    = ((state_q == IDLE) && !req) || (state_q == DONE);
      if ((state_q == LOW) || (state_q == HIGH)) begin
         addr_c = SRAM_AW'(map_addr(req_q.addr, state_q == HIGH, DATA_W'(BASE_ADDR)));
         if (req_q.is_wr) begin
            dq_oe_c  = 1'b1;
            dq_out_c = (state_q == HIGH) ? req_q.wdata[DATA_W-1:HALF_W]
                                         : req_q.wdata[HALF_W-1:0];
            we_n_c   = phase_last && !SINGLE_CYCLE;
         end
      end
   end

   assign SRAM_DQ   = dq_oe_c ? dq_out_c : {HALF_W{1'bz}};
   assign SRAM_ADDR = addr_c;
   assign SRAM_WE_N = we_n_c;
   assign SRAM_OE_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a behavioural SRAM and a
// word-level reference memory.
module tb_sram_controller;

   localparam int unsigned PC      = 3;
   localparam int unsigned AW      = 18;
   localparam int          FRZ     = 1 + 2 * PC;
   localparam int          WE_LOWS = 2 * (PC - 1);

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en;
   logic [31:0] address, write_data;
   logic [31:0] read_data;
   logic        ready;
   wire  [15:0] SRAM_DQ;
   logic [AW-1:0] SRAM_ADDR;
   logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

   sram_controller #(
      .BASE_ADDR    (1024),
      .PHASE_CYCLES (PC),
      .SRAM_AW      (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en),
      .wr_en      (wr_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .SRAM_DQ    (SRAM_DQ),
      .SRAM_ADDR  (SRAM_ADDR),
      .SRAM_WE_N  (SRAM_WE_N),
      .SRAM_OE_N  (SRAM_OE_N),
      .SRAM_CE_N  (SRAM_CE_N),
      .SRAM_UB_N  (SRAM_UB_N),
      .SRAM_LB_N  (SRAM_LB_N)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural SRAM: half-word array, written while WE_N is low, driven
   // onto DQ whenever the bench is not running a write access.
   logic [15:0] sram_mem [int unsigned];
   logic [15:0] sram_out;
   bit          wr_busy = 1'b0;

   function automatic logic [15:0] sram_rd(input int unsigned a);
      return sram_mem.exists(a) ? sram_mem[a] : 16'h0000;
   endfunction

   always @(negedge clk) begin
      if (SRAM_WE_N === 1'b0) sram_mem[int'(SRAM_ADDR)] = SRAM_DQ;
   end

   always @(SRAM_ADDR or negedge clk) sram_out = sram_rd(int'(SRAM_ADDR));

   assign SRAM_DQ = wr_busy ? 16'hzzzz : sram_out;

   // Reference model: 32-bit words indexed by the wrapped word number.
   logic [31:0] ref_mem [int unsigned];

   function automatic int unsigned word_key(input logic [31:0] a);
      logic [31:0] diff;
      diff = a - 32'd1024;
      return (diff / 4) % (1 << (AW - 1));
   endfunction

   typedef struct {
      int          kind;   // 0 read, 1 write, 2 write aborted by reset
      logic [31:0] data;
      int unsigned key;
      int          frz;
      int          wec;
   } exp_t;

   exp_t sb[$];
   bit   mon_en = 1'b0;

   // Monitor: measures each frozen period and checks it at completion.
   int          frz_cnt = 0;
   int          we_cnt  = 0;
   logic [31:0] last_rd = 32'h0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (ready !== 1'b1) begin
            frz_cnt++;
            if (SRAM_WE_N === 1'b0) we_cnt++;
         end else if (frz_cnt > 0) begin
            if (sb.size() == 0) begin
               chk("unexpected_completion", 32'(frz_cnt), 32'h0);
            end else begin
               exp_t        e;
               logic [15:0] lo, hi;
               e = sb.pop_front();
               chk("freeze_cycles", 32'(frz_cnt), 32'(e.frz));
               chk("we_low_cycles", 32'(we_cnt), 32'(e.wec));
               case (e.kind)
                  0: begin
                     chk("read_data", read_data, e.data);
                     last_rd = e.data;
                  end
                  1: begin
                     lo = sram_rd(e.key * 2);
                     hi = sram_rd(e.key * 2 + 1);
                     chk("sram_low_half", {16'h0, lo}, {16'h0, e.data[15:0]});
                     chk("sram_high_half", {16'h0, hi}, {16'h0, e.data[31:16]});
                     chk("read_data_held", read_data, last_rd);
                  end
                  default: begin
                     chk("read_data_after_reset", read_data, 32'h0);
                     last_rd = 32'h0;
                  end
               endcase
            end
            frz_cnt = 0;
            we_cnt  = 0;
         end
      end
   end

   // Issue one access at posedge+1 and hold it until ready returns.
   task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, output int frozen);
      exp_t e;
      e.key = word_key(a);
      e.frz = FRZ;
      if (wr) begin
         ref_mem[e.key] = d;
         e.kind  = 1;
         e.data  = d;
         e.wec   = WE_LOWS;
         wr_busy = 1'b1;
      end else begin
         e.kind = 0;
         e.data = ref_mem.exists(e.key) ? ref_mem[e.key] : 32'h0;
         e.wec  = 0;
      end
      sb.push_back(e);
      rd_en      = rd;
      wr_en      = wr;
      address    = a;
      write_data = d;
      frozen     = 0;
      forever begin
         @(negedge clk);
         if (ready === 1'b1) break;
         frozen++;
         if (frozen >= 40) begin
            chk("access_timeout", 32'(frozen), 32'(FRZ));
            break;
         end
      end
      @(posedge clk);
      #1;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      wr_busy = 1'b0;
   endtask

   task automatic idle_checks(input int n, input bit chk_rd0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         chk("idle_ready", {31'h0, ready}, 32'h1);
         chk("idle_we_n", {31'h0, SRAM_WE_N}, 32'h1);
         chk("idle_dq_released", {16'h0, SRAM_DQ}, {16'h0, sram_out});
         chk("idle_addr", 32'(SRAM_ADDR), 32'h0);
         if (chk_rd0) chk("reset_read_data", read_data, 32'h0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          f1, f2;
      logic [31:0] a, d;
      exp_t        e;
      bit          r, both;

      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      idle_checks(10, 1'b1);

      issue(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, f1);
      issue(1'b1, 1'b0, 32'd1028, 32'h0, f1);
      issue(1'b0, 1'b1, 32'd1032, 32'h0BADF00D, f1);
      issue(1'b1, 1'b1, 32'd1024, 32'h12345678, f1);
      issue(1'b1, 1'b0, 32'd1024, 32'h0, f1);
      chk("dual_req_readback", read_data, 32'h12345678);

      // Reset on the second HIGH cycle of a write.
      e.kind = 2; e.key = word_key(32'd4096); e.data = 32'hCAFEF00D;
      e.frz  = 1 + PC + 2; e.wec = (PC - 1) + 2;
      ref_mem[e.key] = e.data;
      sb.push_back(e);
      wr_busy = 1'b1; wr_en = 1'b1; address = 32'd4096; write_data = e.data;
      repeat (1 + PC + 1) @(posedge clk);
      #1;
      rst = 1'b1; wr_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0; wr_busy = 1'b0;
      idle_checks(4, 1'b1);

      // Back-to-back store/load.
      issue(1'b0, 1'b1, 32'd1036, 32'hA5A55A5A, f1);
      issue(1'b1, 1'b0, 32'd1036, 32'h0, f2);
      chk("b2b_frozen_total", 32'(f1 + f2), 32'(2 * FRZ));

      for (int i = 0; i < 60; i++) begin
         r    = 1'($urandom_range(0, 1));
         both = ($urandom_range(0, 9) == 0);
         a    = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                            : 32'd1024 + 32'(4 * $urandom_range(0, 63));
         d    = 32'($urandom);
         issue(r | both, !r | both, a, d, f1);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      idle_checks(3, 1'b0);
      chk("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
